spi_reg_bank: RTL

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral with a write-only register bank; define SPI_REG_BANK_READBACK_EN to add read frames on cipo
module spi_reg_bank #(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int MAX_W = ADDR_W > DATA_W ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [ADDR_W:0] NREGS = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, RW, ADDR, DATA, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, addr_nxt;
    logic [DATA_W-1:0]  data_q, data_d, data_nxt;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               wr_strobe_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [2:0]         sclk_q, ncs_q, copi_q;
    logic               sclk_rise, ncs_rise, ncs_fall, addr_last, data_last, commit;

    // two synchroniser stages plus one edge-detect stage per SPI input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            ncs_q  <= '0;
            copi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ncs_q  <= {ncs_q[1:0], ncs};
            copi_q <= {copi_q[1:0], copi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];
    assign addr_nxt  = ADDR_W'({addr_q, copi_q[2]});
    assign data_nxt  = DATA_W'({data_q, copi_q[2]});
    assign addr_last = cnt_q == CNT_W'(ADDR_W - 1);
    assign data_last = cnt_q == CNT_W'(DATA_W - 1);

    // frame sequencing; ncs release wins over a coincident sclk edge and decides the commit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        commit  = 1'b0;
        if (ncs_rise) begin
            state_d = IDLE;
            commit  = (state_q == HOLD) && rw_q && ({1'b0, addr_q} < NREGS);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ncs_fall ? RW : IDLE;
                    cnt_d   = '0;
                end
                RW: if (sclk_rise) begin
                    rw_d    = copi_q[2];
                    state_d = ADDR;
                end
                ADDR: if (sclk_rise) begin
                    addr_d  = addr_nxt;
                    cnt_d   = addr_last ? '0 : cnt_q + CNT_W'(1);
                    state_d = addr_last ? DATA : ADDR;
                end
                DATA: if (sclk_rise) begin
                    data_d  = data_nxt;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = data_last ? HOLD : DATA;
                end
                default: ;
            endcase
        end
    end

    // frame state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // register bank, strobe and last-write address all update on the commit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= commit;
            if (commit) wr_addr_q <= addr_q;
            for (int i = 0; i < NUM_REGS; i++) if (commit && addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

`ifdef SPI_REG_BANK_READBACK_EN
    logic [DATA_W-1:0] tx_q, tx_d, rd_word;
    logic              oe_q, oe_d, sclk_fall;

    assign sclk_fall = ~sclk_q[1] & sclk_q[2];

    // addressed register for readback, zero beyond the bank
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) if (addr_nxt == ADDR_W'(i)) rd_word = regs_q[i];
    end

    // load on the last address bit; the fall before the first data rise keeps the MSB on cipo
    always_comb begin
        tx_d = tx_q;
        oe_d = oe_q;
        if (ncs_rise) begin
            oe_d = 1'b0;
        end else if (state_q == ADDR && sclk_rise && addr_last && !rw_q) begin
            tx_d = rd_word;
            oe_d = 1'b1;
        end else if (oe_q && sclk_fall && (state_q == HOLD || cnt_q != '0)) begin
            tx_d = tx_q << 1;
        end
    end

    // readback shifter and output enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
            oe_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
            oe_q <= oe_d;
        end
    end

    assign cipo    = oe_q & tx_q[DATA_W-1];
    assign cipo_oe = oe_q;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif
endmodule
